rle_zrl_packer: RTL and testbench

//  Parametrised successor of the fixed rz-stage amplitude registers in the jpeg_encoder RLE chain.

---
 rtl/rle_zrl_packer_pkg.sv | 30 +++
 rtl/rle_zrl_packer_if.sv | 31 +++
 rtl/rle_zrl_packer_out_reg.sv | 32 +++
 rtl/rle_zrl_packer.sv | 175 +++++++++++++++++
 tb/tb_rle_zrl_packer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rle_zrl_packer_pkg.sv
// rtl/rle_zrl_packer_pkg.sv - shared types and constants for the RLE/ZRL packer
// Package rle_pkg: symbol field widths, FSM state enum, output symbol struct,
// and the fixed ZRL / EOB symbols used by rle_zrl_packer.
package rle_pkg;

  localparam int AMP_W   = 12;
  localparam int SIZE_W  = 4;
  localparam int RUN_W   = 4;
  localparam int MAX_RUN = (1 << RUN_W) - 1;

  localparam logic [RUN_W-1:0] ZRL_RUN = RUN_W'(MAX_RUN);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ZRL    = 2'd1,
    FLUSH  = 2'd2
  } rle_state_t;

  typedef struct packed {
    logic [RUN_W-1:0]  run;
    logic [SIZE_W-1:0] size;
    logic [AMP_W-1:0]  amp;
    logic              dc;
    logic              eob;
  } rle_sym_t;

  localparam rle_sym_t EOB_SYM = '{run: '0, size: '0, amp: '0, dc: 1'b0, eob: 1'b1};
  localparam rle_sym_t ZRL_SYM = '{run: ZRL_RUN, size: '0, amp: '0, dc: 1'b0, eob: 1'b0};

endpackage

// File: rtl/rle_zrl_packer_if.sv
// rtl/rle_zrl_packer_if.sv - coefficient-in / symbol-out handshake bundle
// Signals: din_valid/din_ready/din_size/din_amp (coefficient stream),
//          dout_valid/dout_ready/dout_run/dout_size/dout_amp/dout_dc/dout_eob (symbol stream).
// Modports: slave = packer side, master = producer/consumer side.
interface rle_zrl_packer_if;
  import rle_pkg::*;

  logic              din_valid;
  logic              din_ready;
  logic [SIZE_W-1:0] din_size;
  logic [AMP_W-1:0]  din_amp;

  logic              dout_valid;
  logic              dout_ready;
  logic [RUN_W-1:0]  dout_run;
  logic [SIZE_W-1:0] dout_size;
  logic [AMP_W-1:0]  dout_amp;
  logic              dout_dc;
  logic              dout_eob;

  modport slave (
    input  din_valid, din_size, din_amp, dout_ready,
    output din_ready, dout_valid, dout_run, dout_size, dout_amp, dout_dc, dout_eob
  );

  modport master (
    output din_valid, din_size, din_amp, dout_ready,
    input  din_ready, dout_valid, dout_run, dout_size, dout_amp, dout_dc, dout_eob
  );

endinterface

// File: rtl/rle_zrl_packer_out_reg.sv
// rtl/rle_zrl_packer_out_reg.sv - single-entry valid/ready output register for rle_sym_t
// Ports: clk, rst (sync active-high), in_valid/in_ready/in_sym (load side),
//        out_valid/out_ready/out_sym (downstream side). Contents hold while stalled.
module rle_out_reg
  import rle_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  rle_sym_t in_sym,
  output logic     out_valid,
  input  logic     out_ready,
  output rle_sym_t out_sym
);

  // A new symbol may enter whenever the slot is empty or is leaving this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sym   <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_sym   <= in_sym;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rle_zrl_packer.sv
// rtl/rle_zrl_packer.sv - zig-zag coefficient to (run,size,amp) symbol packer with ZRL/EOB
// Ports: clk, rst (sync active-high), bus (rle_zrl_packer_if.slave: coefficient in,
//        symbol out), sym_cnt/blk_cnt (16-bit saturating statistics).
// Parameters: BLOCK_LEN coefficients per block, CNT_W index / zero-run width.
// Macro RLE_STATS_EN: when defined, sym_cnt counts output transfers and blk_cnt
// counts completed blocks; when undefined both outputs are tied to zero.
module rle_zrl_packer
  import rle_pkg::*;
#(
  parameter int BLOCK_LEN = 64,
  parameter int CNT_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  rle_zrl_packer_if.slave    bus,
  output logic [15:0]        sym_cnt,
  output logic [15:0]        blk_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] ZRL_STEP  = CNT_W'(MAX_RUN + 1);

  rle_state_t        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  zcnt_q, zcnt_d;
  logic [SIZE_W-1:0] hold_size_q, hold_size_d;
  logic [AMP_W-1:0]  hold_amp_q, hold_amp_d;
  logic              hold_last_q, hold_last_d;

  logic     ld;
  rle_sym_t ld_sym;
  logic     can_load;
  rle_sym_t out_sym;
  logic     out_valid;
  logic     acc_xfer;
  logic     is_last;

  assign bus.din_ready = (state_q == ACCEPT) && can_load;
  assign acc_xfer      = bus.din_valid && bus.din_ready;
  assign is_last       = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCEPT;
      idx_q       <= '0;
      zcnt_q      <= '0;
      hold_size_q <= '0;
      hold_amp_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      zcnt_q      <= zcnt_d;
      hold_size_q <= hold_size_d;
      hold_amp_q  <= hold_amp_d;
      hold_last_q <= hold_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    zcnt_d      = zcnt_q;
    hold_size_d = hold_size_q;
    hold_amp_d  = hold_amp_q;
    hold_last_d = hold_last_q;
    ld          = 1'b0;
    ld_sym      = '0;
    unique case (state_q)
      ACCEPT: begin
        if (acc_xfer) begin
          if (idx_q == '0) begin
            ld          = 1'b1;
            ld_sym.size = bus.din_size;
            ld_sym.amp  = bus.din_amp;
            ld_sym.dc   = 1'b1;
            idx_d       = idx_q + 1'b1;
          end else if (bus.din_size == '0) begin
            if (is_last) begin
              // Trailing zeros collapse into EOB; pending ZRLs are never emitted.
              ld     = 1'b1;
              ld_sym = EOB_SYM;
              idx_d  = '0;
              zcnt_d = '0;
            end else begin
              zcnt_d = zcnt_q + 1'b1;
              idx_d  = idx_q + 1'b1;
            end
          end else if (zcnt_q <= MAX_RUN_C) begin
            ld          = 1'b1;
            ld_sym.run  = zcnt_q[RUN_W-1:0];
            ld_sym.size = bus.din_size;
            ld_sym.amp  = bus.din_amp;
            zcnt_d      = '0;
            idx_d       = is_last ? '0 : idx_q + 1'b1;
          end else begin
            // Run too long for one symbol: park the coefficient and drain ZRLs.
            // A last coefficient keeps idx until FLUSH performs the wrap.
            hold_size_d = bus.din_size;
            hold_amp_d  = bus.din_amp;
            hold_last_d = is_last;
            idx_d       = is_last ? idx_q : idx_q + 1'b1;
            state_d     = ZRL;
          end
        end
      end
      ZRL: begin
        if (can_load) begin
          ld = 1'b1;
          if (zcnt_q > MAX_RUN_C) begin
            ld_sym = ZRL_SYM;
            zcnt_d = zcnt_q - ZRL_STEP;
          end else begin
            ld_sym.run  = zcnt_q[RUN_W-1:0];
            ld_sym.size = hold_size_q;
            ld_sym.amp  = hold_amp_q;
            zcnt_d      = '0;
            state_d     = hold_last_q ? FLUSH : ACCEPT;
          end
        end
      end
      FLUSH: begin
        idx_d   = '0;
        state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  rle_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ld),
    .in_ready  (can_load),
    .in_sym    (ld_sym),
    .out_valid (out_valid),
    .out_ready (bus.dout_ready),
    .out_sym   (out_sym)
  );

  assign bus.dout_valid = out_valid;
  assign bus.dout_run   = out_sym.run;
  assign bus.dout_size  = out_sym.size;
  assign bus.dout_amp   = out_sym.amp;
  assign bus.dout_dc    = out_sym.dc;
  assign bus.dout_eob   = out_sym.eob;

`ifdef RLE_STATS_EN
  logic [15:0] sym_cnt_q, blk_cnt_q;
  logic        blk_done;

  // A block completes on EOB, on a directly emitted last coefficient,
  // or in FLUSH after a last coefficient that needed ZRLs.
  assign blk_done = (state_q == FLUSH) ||
                    (acc_xfer && is_last && ((bus.din_size == '0) || (zcnt_q <= MAX_RUN_C)));

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (out_valid && bus.dout_ready && (sym_cnt_q != 16'hFFFF)) sym_cnt_q <= sym_cnt_q + 16'd1;
      if (blk_done && (blk_cnt_q != 16'hFFFF)) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign sym_cnt = sym_cnt_q;
  assign blk_cnt = blk_cnt_q;
`else
  assign sym_cnt = 16'd0;
  assign blk_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rle_zrl_packer.sv
// tb/tb_rle_zrl_packer.sv - scoreboard bench for rle_zrl_packer
module tb_rle_zrl_packer;
  import rle_pkg::*;

  localparam int BL = 64;

  logic        clk;
  logic        rst;
  logic [15:0] sym_cnt;
  logic [15:0] blk_cnt;

  rle_zrl_packer_if bus();

  rle_zrl_packer #(.BLOCK_LEN(BL), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .sym_cnt (sym_cnt),
    .blk_cnt (blk_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_syms = 0;
  int exp_blks = 0;
  int rdy_mode = 0;

  rle_sym_t          exp_q[$];
  logic [SIZE_W-1:0] bsize[BL];
  logic [AMP_W-1:0]  bamp[BL];
  rle_sym_t          cur;

  assign cur = {bus.dout_run, bus.dout_size, bus.dout_amp, bus.dout_dc, bus.dout_eob};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic rle_sym_t mk(int run, int size, logic [AMP_W-1:0] amp, bit dc, bit eob);
    rle_sym_t s;
    s.run  = RUN_W'(run);
    s.size = SIZE_W'(size);
    s.amp  = amp;
    s.dc   = dc;
    s.eob  = eob;
    return s;
  endfunction

  task automatic push(input rle_sym_t s);
    exp_q.push_back(s);
    exp_syms++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: DC first, each nonzero AC carries the zeros before it (16-zero
  // chunks become ZRLs), trailing zeros become one EOB when the block ends in zero.
  task automatic model_block();
    int run;
    run = 0;
    push(mk(0, int'(bsize[0]), bamp[0], 1'b1, 1'b0));
    for (int i = 1; i < BL; i++) begin
      if (bsize[i] == '0) begin
        run++;
      end else begin
        repeat (run / 16) push(mk(15, 0, '0, 1'b0, 1'b0));
        push(mk(run % 16, int'(bsize[i]), bamp[i], 1'b0, 1'b0));
        run = 0;
      end
    end
    if (bsize[BL-1] == '0) push(mk(0, 0, '0, 1'b0, 1'b1));
    exp_blks++;
  endtask

  task automatic send_coef(input logic [SIZE_W-1:0] s, input logic [AMP_W-1:0] a, input int gap);
    int  n;
    bit  acc;
    bus.din_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.din_valid = 1'b1;
    bus.din_size  = s;
    bus.din_amp   = a;
    n   = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.din_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 2000) begin
        checks++;
        errors++;
        $display("FAIL din_accept: coefficient not accepted within %0d cycles", n);
        break;
      end
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic send_block(input int gap_max);
    model_block();
    for (int i = 0; i < BL; i++)
      send_coef(bsize[i], bamp[i], (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
  endtask

  task automatic clear_block();
    for (int i = 0; i < BL; i++) begin
      bsize[i] = '0;
      bamp[i]  = AMP_W'($urandom);
    end
  endtask

  task automatic random_block(input int zero_pct);
    for (int i = 0; i < BL; i++) begin
      bamp[i]  = AMP_W'($urandom);
      bsize[i] = (int'($urandom_range(99, 0)) < zero_pct) ? '0 : SIZE_W'($urandom_range(11, 1));
    end
    bsize[0] = SIZE_W'($urandom_range(11, 0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.dout_valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.dout_valid) begin
      errors++;
      $display("FAIL drain: %0d symbols outstanding dout_valid=%0b, required 0 and 0",
               exp_q.size(), bus.dout_valid);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef RLE_STATS_EN
    chk({tag, "_sym_cnt"}, {16'd0, sym_cnt}, 32'(exp_syms));
    chk({tag, "_blk_cnt"}, {16'd0, blk_cnt}, 32'(exp_blks));
`else
    chk({tag, "_sym_cnt"}, {16'd0, sym_cnt}, 32'd0);
    chk({tag, "_blk_cnt"}, {16'd0, blk_cnt}, 32'd0);
`endif
  endtask

  // Downstream ready pattern: 0 always, 1 toggling, 2 random.
  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.dout_ready = ~bus.dout_ready;
        2:       bus.dout_ready = 1'($urandom_range(1, 0));
        default: bus.dout_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every output transfer against the scoreboard and checks
  // stability under stall and input blocking while a ZRL is pending.
  initial begin
    rle_sym_t prev;
    rle_sym_t e;
    bit       stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!bus.dout_valid || cur !== prev) begin
            errors++;
            $display("FAIL hold: got valid=%0b sym=%0h expected valid=1 sym=%0h", bus.dout_valid, cur, prev);
          end
        end
        if (bus.dout_valid && cur == ZRL_SYM) begin
          checks++;
          if (bus.din_ready) begin
            errors++;
            $display("FAIL zrl_din_ready: got 1 expected 0");
          end
        end
        if (bus.dout_valid && bus.dout_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sym_extra: got run=%0d size=%0d amp=%0h dc=%0b eob=%0b expected no symbol",
                     cur.run, cur.size, cur.amp, cur.dc, cur.eob);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL sym: got run=%0d size=%0d amp=%0h dc=%0b eob=%0b expected run=%0d size=%0d amp=%0h dc=%0b eob=%0b",
                       cur.run, cur.size, cur.amp, cur.dc, cur.eob, e.run, e.size, e.amp, e.dc, e.eob);
            end
          end
          stall = 1'b0;
        end else begin
          stall = bus.dout_valid;
          prev  = cur;
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.din_size  = '0;
    bus.din_amp   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_dout_fields", 32'(cur), 32'd0);
    chk("rst_din_ready", {31'd0, bus.din_ready}, 32'd1);
    chk("rst_sym_cnt", {16'd0, sym_cnt}, 32'd0);
    chk("rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
    @(posedge clk);
    #1;

    // DC only, then all zeros.
    clear_block();
    bsize[0] = 4'd3; bamp[0] = 12'd5;
    send_block(0);
    // Short runs.
    clear_block();
    bsize[1] = 4'd2; bsize[5] = 4'd1;
    send_block(0);
    // One ZRL before idx 21.
    clear_block();
    bsize[21] = 4'd4;
    send_block(0);
    // Nonzero last coefficient after 62 zeros: 3 ZRLs, no EOB, then a fresh block.
    clear_block();
    bsize[63] = 4'd1;
    send_block(0);
    random_block(70);
    send_block(0);
    drain();

    // ZRL case under toggling back-pressure and idle input gaps.
    rdy_mode = 1;
    clear_block();
    bsize[21] = 4'd4;
    send_block(3);
    drain();

    // Randomised blocks, sparse to dense, random back-pressure.
    rdy_mode = 2;
    for (int b = 0; b < 24; b++) begin
      random_block((b % 4 == 0) ? 97 : 40 + int'($urandom_range(55, 0)));
      if (b % 6 == 5) bsize[BL-1] = SIZE_W'($urandom_range(11, 1));
      send_block(2);
    end
    drain();
    check_stats("pre_rst");

    // Reset mid-block at idx 30 with 10 pending zeros.
    rdy_mode = 0;
    clear_block();
    bsize[0] = SIZE_W'($urandom_range(11, 0));
    push(mk(0, int'(bsize[0]), bamp[0], 1'b1, 1'b0));
    for (int i = 1; i < 20; i++) begin
      bsize[i] = 4'd1;
      push(mk(0, 1, bamp[i], 1'b0, 1'b0));
    end
    for (int i = 0; i < 30; i++) send_coef(bsize[i], bamp[i], 0);
    drain();
    check_stats("mid_blk");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_syms = 0;
    exp_blks = 0;
    @(negedge clk);
    chk("rst2_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst2_sym_cnt", {16'd0, sym_cnt}, 32'd0);
    chk("rst2_blk_cnt", {16'd0, blk_cnt}, 32'd0);
    @(posedge clk);
    #1;
    random_block(60);
    send_block(1);
    drain();
    check_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
